serial_twos_complement: RTL and testbench
=========================================

# serial_twos_complement

Parametrised, bit-serial two's complement unit with valid/ready handshakes on both sides. It accepts a WIDTH-bit word and a mode, then processes the word LSB-first at one bit per clock. It returns the word unchanged, its negation, or its absolute value, and flags the most-negative overflow case. It sits between arithmetic datapath stages where area matters more than throughput. It replaces the fixed 4-bit combinational complementer.

## Interface

Parameters:
- WIDTH, 8, data word width in bits; legal range ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream offers in_data/mode this cycle.
- in_ready  out  1  block can accept a word; high only in IDLE.
- in_data  in  WIDTH  operand, two's complement.
- mode  in  2  00 pass, 01 negate, 10 absolute value, 11 reserved (treated as pass).
- out_valid  out  1  result is available; high only in DONE.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  result.
- overflow  out  1  result not representable; valid while out_valid=1.

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid & in_ready:
  - latch in_data into a shift register;
  - latch mode into an internal mode register;
  - compute neg_en = (mode==01) | (mode==10 & in_data[WIDTH-1]);
  - load bit counter with WIDTH-1;
  - clear seen_one;
  - go to SHIFT.
- SHIFT: per cycle, take the shift-register LSB b.
  - Result bit r = (neg_en & seen_one) ? ~b : b.
  - Update seen_one <= seen_one | b.
  - Shift r into the result register MSB-side, so that after WIDTH shifts bit 0 sits at out_data[0].
  - Decrement the counter.
  - When the counter is 0 and the bit has been processed, go to DONE.
- Overflow in SHIFT: overflow is set iff neg_en=1 and the latched operand equals 1 followed by WIDTH-1 zeros. In that case out_data equals the input (e.g. WIDTH=4: 1000 -> 1000). Track this serially, or with one compare at accept.
- Zero operand: negation gives 0 with overflow=0.
- DONE: out_valid=1, and out_data/overflow are held stable. On out_valid & out_ready, go to IDLE.
  - No direct DONE->SHIFT path.
  - A new word cannot be accepted in the same cycle as the result transfer.
- In SHIFT and DONE: in_data and mode changes are ignored; in_ready=0.
- Reserved mode 11 behaves exactly as 00 (neg_en=0, overflow=0).

## Timing

- Reset (asynchronous, any state, including mid-SHIFT): state=IDLE, in_ready=1, out_valid=0, out_data=0, overflow=0, counter=0, seen_one=0. Any partial word is discarded.
- After rst_n deasserts, the first accept is possible on the first rising edge with in_valid=1.
- Accept on edge k: SHIFT occupies cycles k+1 .. k+WIDTH; DONE is entered at edge k+WIDTH, so out_valid rises WIDTH cycles after the accept edge.
- With out_ready=1 held high, the result transfers on edge k+WIDTH+1 and in_ready is high from that edge on.
  - Peak throughput: one word per WIDTH+2 cycles.
- Backpressure: out_valid stays asserted, and out_data/overflow stay constant, for any number of cycles until out_ready=1.
- out_ready has no effect outside DONE.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Test plan

- Exhaustive WIDTH=4, mode=01, all 16 inputs 0000..1111, out_ready=1. Required:
  - each out_data = (-in) mod 16;
  - overflow=1 only for 1000;
  - out_valid exactly 4 cycles after each accept.
- WIDTH=4, mode=10:
  - 1110 -> 0010, overflow 0;
  - 0101 -> 0101, overflow 0;
  - 1000 -> 1000, overflow 1.
- WIDTH=8, mode=00 and mode=11: 0xA5 -> 0xA5, overflow 0. Mode=01: 0x01 -> 0xFF and 0x00 -> 0x00.
- Backpressure, WIDTH=8, negate 0x80:
  - hold out_ready=0 for 10 cycles; out_valid=1 with out_data=0x80, overflow=1 held constant;
  - in_ready=0 throughout, and an in_valid pulse offering 0x33 during this time is ignored;
  - release out_ready, then in_ready rises next cycle.
- Reset mid-operation, WIDTH=8, negate 0x3C: drop rst_n 3 cycles after accept. All outputs zero and in_ready=1 immediately (asynchronously). A subsequent 0x3C completes to 0xC4.
- Change in_data/mode during SHIFT: the result reflects only the values latched at accept.

Source files
------------

// File: rtl/serial_twos_complement.sv
// serial_twos_complement: LSB-first bit-serial pass/negate/abs with valid/ready handshakes
module serial_twos_complement #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, seen_q, seen_d, ovf_q, ovf_d;
  logic neg_in, r;
  assign neg_in = (mode == 2'b01) | ((mode == 2'b10) & in_data[WIDTH-1]);
  // Bits below and including the first one pass; all later bits invert.
  assign r = (neg_q & seen_q) ? ~sr_q[0] : sr_q[0];
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_data = res_q;
  assign overflow = ovf_q & (state_q == DONE);
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    res_d = res_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    seen_d = seen_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sr_d = in_data;
        neg_d = neg_in;
        ovf_d = neg_in & (in_data == MIN_VAL);
        cnt_d = CW'(WIDTH - 1);
        seen_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sr_d = sr_q >> 1;
        res_d = {r, res_q[WIDTH-1:1]};
        seen_d = seen_q | sr_q[0];
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? DONE : SHIFT;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      seen_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      seen_q <= seen_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_serial_twos_complement.sv
// tb_serial_twos_complement: directed scoreboard bench for WIDTH=4 and WIDTH=8 instances
module tb_serial_twos_complement;
  typedef struct packed {logic [7:0] data; logic ovf;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iv4 = 1'b0, ir4, ov4, or4 = 1'b1, of4;
  logic [3:0] id4 = '0, od4;
  logic [1:0] m4 = '0;
  logic iv8 = 1'b0, ir8, ov8, or8 = 1'b1, of8;
  logic [7:0] id8 = '0, od8;
  logic [1:0] m8 = '0;
  exp_t q4[$], q8[$];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  serial_twos_complement #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .in_data(id4), .mode(m4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .overflow(of4));
  serial_twos_complement #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .in_data(id8), .mode(m8), .out_valid(ov8), .out_ready(or8), .out_data(od8), .overflow(of8));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input int w, input logic [7:0] x, input logic [1:0] m);
    logic [7:0] mask, minv, res;
    logic neg;
    mask = 8'((1 << w) - 1);
    minv = 8'(1 << (w - 1));
    neg = (m == 2'b01) || (m == 2'b10 && (x & minv) != 0);
    res = neg ? ((~x + 8'd1) & mask) : x;
    return '{data: res, ovf: neg && x == minv};
  endfunction
  task automatic run4(input logic [3:0] d, input logic [1:0] m);
    int lat;
    exp_t e;
    @(negedge clk);
    iv4 = 1'b1; id4 = d; m4 = m;
    @(posedge clk); #1;
    iv4 = 1'b0;
    q4.push_back(model(4, {4'h0, d}, m));
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ov4 && lat < 20);
    chk($sformatf("w4_lat_%h_%0d", d, m), lat, 4);
    if (q4.size() == 0) chk("w4_sb_empty", 0, 1);
    else begin
      e = q4.pop_front();
      chk($sformatf("w4_data_%h_%0d", d, m), {28'h0, od4}, {24'h0, e.data});
      chk($sformatf("w4_ovf_%h_%0d", d, m), {31'h0, of4}, {31'h0, e.ovf});
    end
    @(posedge clk); #1;
  endtask
  task automatic run8(input logic [7:0] d, input logic [1:0] m);
    int lat;
    exp_t e;
    @(negedge clk);
    iv8 = 1'b1; id8 = d; m8 = m;
    chk("w8_in_ready_idle", {31'h0, ir8}, 1);
    @(posedge clk); #1;
    iv8 = 1'b0; id8 = ~d ^ 8'h5A; m8 = ~m;
    q8.push_back(model(8, d, m));
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ov8 && lat < 40);
    chk($sformatf("w8_lat_%h_%0d", d, m), lat, 8);
    if (q8.size() == 0) chk("w8_sb_empty", 0, 1);
    else begin
      e = q8.pop_front();
      chk($sformatf("w8_data_%h_%0d", d, m), {24'h0, od8}, {24'h0, e.data});
      chk($sformatf("w8_ovf_%h_%0d", d, m), {31'h0, of8}, {31'h0, e.ovf});
    end
  endtask
  initial begin
    #2;
    chk("rst_ir8", {31'h0, ir8}, 1);
    chk("rst_ov8", {31'h0, ov8}, 0);
    chk("rst_od8", {24'h0, od8}, 0);
    chk("rst_of8", {31'h0, of8}, 0);
    chk("rst_ir4", {31'h0, ir4}, 1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) run4(4'(i), 2'b01);
    run4(4'b1110, 2'b10);
    run4(4'b0101, 2'b10);
    run4(4'b1000, 2'b10);
    run8(8'hA5, 2'b00);
    @(posedge clk); #1;
    run8(8'hA5, 2'b11);
    @(posedge clk); #1;
    run8(8'h01, 2'b01);
    @(posedge clk); #1;
    run8(8'h00, 2'b01);
    @(posedge clk); #1;
    run8(8'h9C, 2'b10);
    @(posedge clk); #1;
    chk("w8_ir_after_xfer", {31'h0, ir8}, 1);
    @(negedge clk); or8 = 1'b0;
    run8(8'h80, 2'b01);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin @(negedge clk); iv8 = 1'b1; id8 = 8'h33; m8 = 2'b00; end
      @(posedge clk); #1;
      iv8 = 1'b0;
      chk($sformatf("bp_ov_%0d", c), {31'h0, ov8}, 1);
      chk($sformatf("bp_od_%0d", c), {24'h0, od8}, 8'h80);
      chk($sformatf("bp_of_%0d", c), {31'h0, of8}, 1);
      chk($sformatf("bp_ir_%0d", c), {31'h0, ir8}, 0);
    end
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ir", {31'h0, ir8}, 1);
    chk("bp_release_ov", {31'h0, ov8}, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_0x33_ignored", {30'h0, ov8, ir8}, 2'b01);
    @(negedge clk); iv8 = 1'b1; id8 = 8'h3C; m8 = 2'b01;
    @(posedge clk); #1; iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ir", {31'h0, ir8}, 1);
    chk("mid_rst_ov", {31'h0, ov8}, 0);
    chk("mid_rst_od", {24'h0, od8}, 0);
    chk("mid_rst_of", {31'h0, of8}, 0);
    @(negedge clk); rst_n = 1'b1;
    run8(8'h3C, 2'b01);
    @(posedge clk); #1;
    chk("sb4_drained", q4.size(), 0);
    chk("sb8_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
